// File: rtl/delay_sum_pkg.sv
// Shared types and default widths for the delay/sum sequencer.
package delay_sum_pkg;

  localparam int unsigned DefW    = 32;
  localparam int unsigned DefCntW = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRE_ISSUE  = 3'd1,
    PRE_GAP    = 3'd2,
    WAIT_RES   = 3'd3,
    FINAL_GAP  = 3'd4,
    STREAM     = 3'd5,
    STREAM_GAP = 3'd6
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear (clear beats increment).
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/delay_sum_seq.sv
// Preload/result/stream sequencer feeding the shared multiplier.
// Define DELAY_SUM_SEQ_TIMEOUT_EN to add a result-wait timeout.
module delay_sum_seq
  import delay_sum_pkg::*;
#(
  parameter int unsigned W           = DefW,
  parameter int unsigned N_PRE       = 2,
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               GlobalReset,
  input  logic               start,
  input  logic [N_PRE*W-1:0] pre_ops,
  input  logic [W-1:0]       result_i,
  input  logic               result_vld,
  input  logic [W-1:0]       x_i,
  input  logic               srdyi_i,
  input  logic               output_ready,
  output logic [W-1:0]       mult_1,
  output logic               delay_o,
  output logic [W-1:0]       z_o,
  output logic [W-1:0]       adc_final,
  output logic               clk_stop,
  output logic               busy,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               timeout_o
);

  localparam int unsigned IDX_W = (N_PRE > 1) ? $clog2(N_PRE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PRE - 1);

  if (N_PRE < 1 || N_PRE > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("delay_sum_seq: N_PRE must be 1..8 and TIMEOUT_CYC at least 1");
  end

  state_e           state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     slot [N_PRE];
  logic             tmo_hit;
  logic             drop_inc;

  for (genvar k = 0; k < N_PRE; k++) begin : g_slot
    assign slot[k] = pre_ops[k*W +: W];
  end

  assign busy = (state != IDLE);

  // A flush cycle is not an FSM cycle, so nothing is dropped on it.
  assign drop_inc = (state == STREAM_GAP) && srdyi_i && !output_ready;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (GlobalReset),
    .clr   (1'b0),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

`ifdef DELAY_SUM_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts WAIT_RES cycles already spent; fires on the TIMEOUT_CYC-th one.
  sat_counter #(
    .WIDTH (TMO_W)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst   (GlobalReset),
    .clr   ((state != WAIT_RES) || output_ready),
    .inc   (1'b1),
    .count (tmo_cnt)
  );

  assign tmo_hit = (state == WAIT_RES) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      timeout_o <= 1'b0;
    end else if (!output_ready && tmo_hit && !result_vld) begin
      timeout_o <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state     <= IDLE;
      idx       <= '0;
      mult_1    <= '0;
      delay_o   <= 1'b0;
      z_o       <= '0;
      adc_final <= '0;
      clk_stop  <= 1'b0;
    end else if (output_ready) begin
      z_o      <= x_i;
      delay_o  <= 1'b0;
      clk_stop <= 1'b0;
      state    <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            state <= PRE_ISSUE;
          end
        end
        PRE_ISSUE: begin
          mult_1  <= slot[idx];
          delay_o <= 1'b1;
          state   <= PRE_GAP;
        end
        PRE_GAP: begin
          delay_o <= 1'b0;
          if (idx == LAST_IDX) begin
            state <= WAIT_RES;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= PRE_ISSUE;
          end
        end
        WAIT_RES: begin
          if (result_vld) begin
            adc_final <= result_i;
            mult_1    <= result_i;
            delay_o   <= 1'b1;
            state     <= FINAL_GAP;
          end else if (tmo_hit) begin
            adc_final <= '0;
            mult_1    <= '0;
            delay_o   <= 1'b1;
            state     <= FINAL_GAP;
          end
        end
        FINAL_GAP: begin
          delay_o  <= 1'b0;
          clk_stop <= 1'b1;
          state    <= STREAM;
        end
        STREAM: begin
          if (srdyi_i) begin
            z_o     <= x_i;
            mult_1  <= x_i;
            delay_o <= 1'b1;
            state   <= STREAM_GAP;
          end
        end
        STREAM_GAP: begin
          delay_o <= 1'b0;
          state   <= STREAM;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_sum_seq.sv
// Directed bench for delay_sum_seq with a timeline-based reference model.
module tb_delay_sum_seq;

  localparam int W     = 32;
  localparam int N_PRE = 2;
  localparam int TCYC  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               GlobalReset, start, result_vld, srdyi_i, output_ready;
  logic [N_PRE*W-1:0] pre_ops;
  logic [W-1:0]       result_i, x_i;

  logic [W-1:0] mult_1, z_o, adc_final;
  logic         delay_o, clk_stop, busy, timeout_o;
  logic [7:0]   drop_cnt;

  logic [W-1:0] mult_1_s, z_o_s, adc_final_s;
  logic         delay_o_s, clk_stop_s, busy_s, timeout_o_s;
  logic [1:0]   drop_cnt_s;

  delay_sum_seq #(.W(W), .N_PRE(N_PRE), .CNT_W(8), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .GlobalReset(GlobalReset), .start(start), .pre_ops(pre_ops),
    .result_i(result_i), .result_vld(result_vld), .x_i(x_i), .srdyi_i(srdyi_i),
    .output_ready(output_ready), .mult_1(mult_1), .delay_o(delay_o), .z_o(z_o),
    .adc_final(adc_final), .clk_stop(clk_stop), .busy(busy), .drop_cnt(drop_cnt),
    .timeout_o(timeout_o)
  );

  delay_sum_seq #(.W(W), .N_PRE(N_PRE), .CNT_W(2), .TIMEOUT_CYC(TCYC)) dut_sat (
    .clk(clk), .GlobalReset(GlobalReset), .start(start), .pre_ops(pre_ops),
    .result_i(result_i), .result_vld(result_vld), .x_i(x_i), .srdyi_i(srdyi_i),
    .output_ready(output_ready), .mult_1(mult_1_s), .delay_o(delay_o_s), .z_o(z_o_s),
    .adc_final(adc_final_s), .clk_stop(clk_stop_s), .busy(busy_s), .drop_cnt(drop_cnt_s),
    .timeout_o(timeout_o_s)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference model: phase 0 idle, 1 preload timeline, 2 waiting, 3 final, 4 streaming.
  int          ph, t, w, drops;
  bit          cool, mdl_on = 1'b0;
  logic [31:0] e_mult, e_z, e_adc;
  bit          e_dly, e_stop, e_tout;

  always @(posedge clk) begin
    if (GlobalReset) begin
      ph = 0; t = 0; w = 0; drops = 0; cool = 1'b0;
      e_mult = '0; e_z = '0; e_adc = '0; e_dly = 1'b0; e_stop = 1'b0; e_tout = 1'b0;
      mdl_on = 1'b1;
    end else if (output_ready) begin
      e_z = x_i; e_dly = 1'b0; e_stop = 1'b0; ph = 0;
    end else begin
      e_dly = 1'b0;
      case (ph)
        0: if (start) begin ph = 1; t = 0; end
        1: begin
          t++;
          if (t % 2 == 1) begin
            e_mult = pre_ops[((t - 1) / 2) * W +: W];
            e_dly  = 1'b1;
          end else if (t == 2 * N_PRE) begin
            ph = 2; w = 0;
          end
        end
        2: begin
          w++;
          if (result_vld) begin
            e_adc = result_i; e_mult = result_i; e_dly = 1'b1; ph = 3;
          end
`ifdef DELAY_SUM_SEQ_TIMEOUT_EN
          else if (w == TCYC) begin
            e_adc = '0; e_mult = '0; e_dly = 1'b1; e_tout = 1'b1; ph = 3;
          end
`endif
        end
        3: begin e_stop = 1'b1; ph = 4; cool = 1'b0; end
        4: begin
          if (cool) begin
            cool = 1'b0;
            if (srdyi_i) drops++;
          end else if (srdyi_i) begin
            e_z = x_i; e_mult = x_i; e_dly = 1'b1; cool = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      check("mult_1", mult_1, e_mult);
      check("delay_o", delay_o, e_dly);
      check("z_o", z_o, e_z);
      check("adc_final", adc_final, e_adc);
      check("clk_stop", clk_stop, e_stop);
      check("busy", busy, ph != 0);
      check("drop_cnt", drop_cnt, (drops > 255) ? 255 : drops);
      check("timeout_o", timeout_o, e_tout);
      check("sat.mult_1", mult_1_s, e_mult);
      check("sat.delay_o", delay_o_s, e_dly);
      check("sat.busy", busy_s, ph != 0);
      check("sat.drop_cnt", drop_cnt_s, (drops > 3) ? 3 : drops);
    end
  end

  int pulses;

  initial begin
    GlobalReset = 1'b1; start = 1'b0; pre_ops = {32'h22, 32'h11};
    result_i = '0; result_vld = 1'b0; x_i = '0; srdyi_i = 1'b0; output_ready = 1'b0;
    tick(); tick();
    GlobalReset = 1'b0;
    check("lit.rst_mult", mult_1, 0);
    check("lit.rst_busy", busy, 0);
    check("lit.rst_stop", clk_stop, 0);
    check("lit.rst_drop", drop_cnt, 0);

    // Preload, with a stray result_vld that must be ignored
    start = 1'b1; result_vld = 1'b1; result_i = 32'hDEAD;
    tick();
    start = 1'b0;
    tick();
    check("lit.pre0_mult", mult_1, 32'h11);
    check("lit.pre0_dly", delay_o, 1);
    check("lit.pre0_busy", busy, 1);
    tick();
    check("lit.pre_gap_dly", delay_o, 0);
    result_vld = 1'b0;
    tick();
    check("lit.pre1_mult", mult_1, 32'h22);
    check("lit.pre1_dly", delay_o, 1);
    tick(); tick(); tick();
    check("lit.wait_adc", adc_final, 0);

    // Result capture
    result_i = 32'hABCD; result_vld = 1'b1;
    tick();
    result_vld = 1'b0;
    check("lit.res_adc", adc_final, 32'hABCD);
    check("lit.res_mult", mult_1, 32'hABCD);
    check("lit.res_dly", delay_o, 1);
    check("lit.res_stop", clk_stop, 0);
    tick();
    check("lit.fin_stop", clk_stop, 1);
    check("lit.fin_dly", delay_o, 0);

    // Back-to-back samples 1..6
    pulses = 0;
    srdyi_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      x_i = i;
      tick();
      pulses += int'(delay_o);
      check("lit.stream_z", z_o, (i % 2 == 1) ? i : i - 1);
    end
    srdyi_i = 1'b0;
    tick();
    check("lit.stream_pulses", pulses, 3);
    check("lit.stream_z_last", z_o, 5);
    check("lit.stream_drop", drop_cnt, 3);

    // Saturation: ten more drops
    srdyi_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      x_i = 100 + i;
      tick();
    end
    srdyi_i = 1'b0;
    tick();
    check("lit.drop13", drop_cnt, 13);
    check("lit.drop_sat", drop_cnt_s, 3);

    // Flush
    x_i = 32'h55; output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    check("lit.flush_z", z_o, 32'h55);
    check("lit.flush_stop", clk_stop, 0);
    check("lit.flush_busy", busy, 0);
    check("lit.flush_adc", adc_final, 32'hABCD);
    check("lit.flush_drop", drop_cnt, 13);

    // Start coincident with flush is lost
    start = 1'b1; output_ready = 1'b1;
    tick();
    start = 1'b0; output_ready = 1'b0;
    tick();
    check("lit.start_lost", busy, 0);

    // Reset while in PRE_GAP, then a fresh start
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    GlobalReset = 1'b1;
    tick();
    GlobalReset = 1'b0;
    check("lit.mid_rst_mult", mult_1, 0);
    check("lit.mid_rst_drop", drop_cnt, 0);
    check("lit.mid_rst_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("lit.reissue_mult", mult_1, 32'h11);
    check("lit.reissue_dly", delay_o, 1);
    tick(); tick(); tick();
    // In WAIT_RES; start while busy is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("lit.wait_nodly", delay_o, 0);
    tick();
`ifdef DELAY_SUM_SEQ_TIMEOUT_EN
    check("lit.tmo_flag", timeout_o, 1);
    check("lit.tmo_adc", adc_final, 0);
    check("lit.tmo_dly", delay_o, 1);
`else
    check("lit.tmo_flag", timeout_o, 0);
    check("lit.tmo_dly", delay_o, 0);
    check("lit.tmo_busy", busy, 1);
`endif
    tick();

    // Result arriving on the timeout cycle is captured
    output_ready = 1'b1;
    tick();
    output_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    repeat (3) tick();
    result_i = 32'h1234; result_vld = 1'b1;
    tick();
    result_vld = 1'b0;
    check("lit.race_adc", adc_final, 32'h1234);
    check("lit.race_dly", delay_o, 1);
`ifdef DELAY_SUM_SEQ_TIMEOUT_EN
    check("lit.race_tmo_sticky", timeout_o, 1);
`else
    check("lit.race_tmo", timeout_o, 0);
`endif
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/delay_sum_seq.md
Name: delay_sum_seq

Overview:
- Parametrised successor to the fixed-schedule delay/sum stage.
- Issues a programmable list of preload operands to the downstream multiplier, then captures one result into adc_final and raises clk_stop.
- Then forwards streaming samples, each with a one-cycle strobe, and counts samples dropped during strobe gaps.
- Sits between the ADC front end and the shared multiplier; replaces the hard-coded count_global schedule.

Parameters:
- W, 32, data width of all operand/sample buses.
- N_PRE, 2, number of preload operands issued before result wait (1..8).
- CNT_W, 8, width of saturating drop counter.
- TIMEOUT_CYC, 255, result-wait timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- GlobalReset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins sequence when in IDLE, ignored otherwise.
- pre_ops  in  N_PRE*W  preload operands; slot k = bits [k*W +: W], issued k=0 first.
- result_i  in  W  multiplier result.
- result_vld  in  1  result_i valid this cycle.
- x_i  in  W  streaming sample.
- srdyi_i  in  1  x_i valid this cycle.
- output_ready  in  1  flush request.
- mult_1  out  W  operand to multiplier.
- delay_o  out  1  operand strobe, high exactly one cycle per operand.
- z_o  out  W  forwarded sample.
- adc_final  out  W  captured result.
- clk_stop  out  1  set after result capture.
- busy  out  1  high in any state other than IDLE.
- drop_cnt  out  CNT_W  saturating count of samples dropped.
- timeout_o  out  1  sticky result-wait timeout flag.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the preload index is 0. Reset overrides every other input, including mid-sequence.
- Priority after reset: output_ready, then the FSM.
- output_ready:
  - z_o <= x_i.
  - delay_o <= 0; clk_stop <= 0.
  - State goes to IDLE.
  - mult_1, adc_final and drop_cnt hold.
- IDLE: on start -> PRE_ISSUE with idx=0.
- PRE_ISSUE: mult_1 <= pre_ops[idx]; delay_o <= 1; -> PRE_GAP.
- PRE_GAP: delay_o <= 0. If idx==N_PRE-1 -> WAIT_RES, else idx++ and -> PRE_ISSUE.
  - Preload latency: strobes fall on start+1, +3, +5, ... (2-cycle period).
- WAIT_RES: on result_vld, adc_final <= result_i; mult_1 <= result_i; delay_o <= 1; -> FINAL_GAP. result_vld seen in any other state is ignored.
- FINAL_GAP: delay_o <= 0; clk_stop <= 1; -> STREAM.
- STREAM: on srdyi_i, z_o <= x_i; mult_1 <= x_i; delay_o <= 1; -> STREAM_GAP.
- STREAM_GAP: delay_o <= 0; -> STREAM. If srdyi_i is high in this state, the sample is dropped and drop_cnt increments, saturating at 2^CNT_W-1.
- Back-to-back srdyi_i: every other sample is accepted.
- clk_stop stays high until output_ready or reset.
- drop_cnt clears only on reset. A new start does not clear it.
- start while busy has no effect.
- start coincident with output_ready: flush wins, and start is lost.

Optional Feature:
- Macro: DELAY_SUM_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_RES.
  - If TIMEOUT_CYC cycles pass without result_vld: adc_final <= 0; mult_1 <= 0; delay_o <= 1; timeout_o <= 1 (sticky until reset); -> FINAL_GAP.
  - result_vld on the timeout cycle wins, and its result is captured normally.
- Undefined: WAIT_RES waits indefinitely, timeout_o is tied 0, and no counter logic exists.

Decomposition:
- Package delay_sum_pkg holds:
  - state enum (IDLE, PRE_ISSUE, PRE_GAP, WAIT_RES, FINAL_GAP, STREAM, STREAM_GAP);
  - default W and CNT_W constants.
- Sub-module sat_counter (parametrised width, inc, clr, sync reset) is used for drop_cnt and reused for the timeout counter.

Test Plan:
- Preload: W=32, N_PRE=2, pre_ops={0x22,0x11}, start at cycle 0 -> mult_1=0x11 with delay_o at cycle 1, mult_1=0x22 with delay_o at cycle 3, busy=1.
- Result capture: in WAIT_RES drive result_i=0xABCD with result_vld for 1 cycle -> adc_final=mult_1=0xABCD with delay_o for 1 cycle, clk_stop=1 one cycle later.
- Streaming: in STREAM hold srdyi_i high 6 cycles with x_i=1..6 -> z_o takes 1,3,5, three delay_o pulses, drop_cnt=3.
- Saturation: CNT_W=2, 10 dropped samples -> drop_cnt=3.
- Flush/reset: output_ready in STREAM with x_i=0x55 -> z_o=0x55, clk_stop=0, busy=0. GlobalReset during PRE_GAP -> all outputs 0, then a fresh start reissues slot 0.
- Timeout (macro on, TIMEOUT_CYC=4): no result_vld -> adc_final=0, timeout_o=1, delay_o pulse 4 cycles after WAIT_RES entry.
